// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad lock controller.
//   state_t     : controller FSM states
//   DIGIT_W     : width of one keypad digit
//   MAX_DIGIT   : largest digit code accepted into a sequence
//   digit_valid : true when a scanned key code is a decimal digit
package keylock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return (d <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/keylock_timer.sv
// Loadable down-counter used for both the open window and the lockout window.
//   hwclk    : clock (posedge)
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over tick)
//   load_val : value to load
//   tick     : decrement by one; holds at zero
//   value    : current count
//   zero     : count is zero
module keylock_timer #(
  parameter int W = 32
) (
  input  logic         hwclk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge hwclk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (tick && (value != '0)) begin
      value <= value - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/keylock_ctrl.sv
// Keypad code lock controller.
//   hwclk        : 12 MHz clock, all logic on posedge
//   rst          : synchronous active-high reset
//   button       : scanned digit code, valid on the release of bstate
//   bstate       : key-pressed indication; a digit is taken on its falling edge
//   unlocked     : high while the lock is open
//   locked_out   : high while further entry is blocked after repeated failures
//   digit_count  : digits accepted in the current sequence
//   fail_pulse   : one-cycle pulse per wrong code
//   code_updated : one-cycle pulse when a new code has been stored
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter logic [31:0]             UNLOCK_CYCLES  = 32'd60000000,
  parameter logic [31:0]             LOCKOUT_CYCLES = 32'd120000000
) (
  input  logic         hwclk,
  input  logic         rst,
  input  logic [3:0]   button,
  input  logic         bstate,
  output logic         unlocked,
  output logic         locked_out,
  output logic [2:0]   digit_count,
  output logic         fail_pulse,
  output logic         code_updated
);

  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam logic [2:0] LAST_IDX  = 3'(CODE_LEN - 1);
  localparam logic [2:0] FAIL_LAST = 3'(MAX_FAILS - 1);

  state_t              state, state_next;
  logic                bstate_q;
  logic [CODE_W-1:0]   entry;
  logic [CODE_W-1:0]   stored_code;
  logic [CODE_W-1:0]   entry_shift;
  logic [2:0]          fail_cnt;

  logic                dig_evt;
  logic                accept;
  logic                seq_done;
  logic                code_match;

  logic                tmr_load;
  logic [31:0]         tmr_load_val;
  logic                tmr_tick;
  logic [31:0]         tmr_value;
  logic                tmr_zero;
  logic                tmr_expire;

  logic                clr_seq;
  logic                commit;
  logic                fail_inc;
  logic                fail_clr;

  keylock_timer #(.W(32)) u_timer (
    .hwclk    (hwclk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // A digit is taken on release; only LOCKED and OPEN collect digits.
  assign dig_evt     = bstate_q & ~bstate;
  assign accept      = dig_evt && digit_valid(button) &&
                       ((state == ST_LOCKED) || (state == ST_OPEN));
  assign seq_done    = accept && (digit_count == LAST_IDX);
  assign entry_shift = (entry << DIGIT_W) | CODE_W'(button);
  assign code_match  = (entry == stored_code);

  // Leave on the cycle the count steps from 1 to 0, so a window of N
  // cycles keeps the state for exactly N cycles.
  assign tmr_expire  = tmr_zero || (tmr_value == 32'd1);

  assign unlocked    = (state == ST_OPEN);
  assign locked_out  = (state == ST_LOCKOUT);

  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_tick     = 1'b0;
    clr_seq      = 1'b0;
    commit       = 1'b0;
    fail_inc     = 1'b0;
    fail_clr     = 1'b0;
    fail_pulse   = 1'b0;
    case (state)
      ST_LOCKED: begin
        if (seq_done) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        clr_seq = 1'b1;
        if (code_match) begin
          fail_clr     = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = UNLOCK_CYCLES;
          state_next   = ST_OPEN;
        end else begin
          fail_pulse = 1'b1;
          if (fail_cnt == FAIL_LAST) begin
            fail_clr     = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = LOCKOUT_CYCLES;
            state_next   = ST_LOCKOUT;
          end else begin
            fail_inc   = 1'b1;
            state_next = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        tmr_tick = 1'b1;
        // Completion wins over a simultaneous expiry.
        if (seq_done) begin
          commit       = 1'b1;
          clr_seq      = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
          state_next   = ST_LOCKED;
        end else if (tmr_expire) begin
          clr_seq    = 1'b1;
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        tmr_tick = 1'b1;
        if (tmr_expire) begin
          clr_seq    = 1'b1;
          state_next = ST_LOCKED;
        end
      end
      default: begin
        clr_seq    = 1'b1;
        state_next = ST_LOCKED;
      end
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state        <= ST_LOCKED;
      bstate_q     <= 1'b0;
      stored_code  <= DEFAULT_CODE;
      entry        <= '0;
      digit_count  <= '0;
      fail_cnt     <= '0;
      code_updated <= 1'b0;
    end else begin
      state        <= state_next;
      bstate_q     <= bstate;
      code_updated <= commit;
      if (commit) stored_code <= entry_shift;
      if (clr_seq) begin
        entry       <= '0;
        digit_count <= '0;
      end else if (accept) begin
        entry       <= entry_shift;
        digit_count <= digit_count + 3'd1;
      end
      if (fail_clr)      fail_cnt <= '0;
      else if (fail_inc) fail_cnt <= fail_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_keylock_ctrl.sv
module tb_keylock_ctrl;

  logic       hwclk;
  logic       rst;
  logic [3:0] button;
  logic       bstate;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] digit_count;
  logic       fail_pulse;
  logic       code_updated;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fail_seen = 0;
  int upd_seen  = 0;

  keylock_ctrl #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (32'd100),
    .LOCKOUT_CYCLES (32'd200)
  ) dut (
    .hwclk        (hwclk),
    .rst          (rst),
    .button       (button),
    .bstate       (bstate),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .digit_count  (digit_count),
    .fail_pulse   (fail_pulse),
    .code_updated (code_updated)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) cyc <= cyc + 1;
  always @(negedge hwclk) begin
    if (fail_pulse)   fail_seen <= fail_seen + 1;
    if (code_updated) upd_seen  <= upd_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  // Press and release one key; returns just after the edge that takes the digit.
  task automatic press(input logic [3:0] d);
    @(negedge hwclk);
    button = d;
    bstate = 1'b1;
    @(negedge hwclk);
    bstate = 1'b0;
    @(posedge hwclk);
    #1;
  endtask

  task automatic enter4(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++) begin
      press(c[15:12]);
      c = c << 4;
    end
  endtask

  task automatic wait_open_end(input string tag);
    for (int i = 0; i < 300 && unlocked; i++) tick(1);
    check(tag, unlocked, 0);
  endtask

  int f0;
  int t0;

  initial begin
    rst = 1'b1; button = 4'd0; bstate = 1'b0;
    tick(3);
    @(negedge hwclk) rst = 1'b0;
    tick(1);
    check("rst_unlocked", unlocked, 0);
    check("rst_lockout", locked_out, 0);
    check("rst_count", digit_count, 0);
    check("rst_updated", code_updated, 0);
    check("rst_fail", fail_pulse, 0);

    // Non-digit keys are ignored; default code unlocks after 2 cycles.
    press(4'hB);  check("hex_b_count0", digit_count, 0);
    press(4'd1);  check("count1", digit_count, 1);
    press(4'd2);  check("count2", digit_count, 2);
    press(4'hB);  check("hex_b_count2", digit_count, 2);
    press(4'd3);  check("count3", digit_count, 3);
    press(4'd4);
    check("check_cycle_locked", unlocked, 0);
    check("check_cycle_count", digit_count, 4);
    tick(1);
    check("unlock_lat2", unlocked, 1);
    check("open_count0", digit_count, 0);
    check("no_fail_pulse", fail_seen, 0);

    // Open window lasts exactly 100 cycles.
    tick(99);
    check("open_last_cycle", unlocked, 1);
    tick(1);
    check("open_expired", unlocked, 0);

    // Partial entry during OPEN is discarded on expiry.
    enter4(16'h1234); tick(1);
    check("unlock2", unlocked, 1);
    press(4'd5); press(4'd5);
    check("partial_count", digit_count, 2);
    wait_open_end("partial_expire");
    check("partial_cleared", digit_count, 0);
    enter4(16'h1234); tick(1);
    check("code_unchanged", unlocked, 1);

    // Change code to 9876 while open.
    enter4(16'h9876);
    check("upd_pulse", code_updated, 1);
    check("upd_locked", unlocked, 0);
    check("upd_count0", digit_count, 0);
    tick(1);
    check("upd_pulse_end", code_updated, 0);
    check("upd_once", upd_seen, 1);
    enter4(16'h1234);
    check("old_code_fail", fail_pulse, 1);
    tick(1);
    check("old_code_locked", unlocked, 0);
    check("old_code_no_lockout", locked_out, 0);
    enter4(16'h9876); tick(1);
    check("new_code_unlock", unlocked, 1);
    wait_open_end("new_code_expire");

    // Three wrong codes -> lockout for 200 cycles.
    f0 = fail_seen;
    for (int k = 0; k < 3; k++) begin
      enter4(16'h1235);
      check("wrong_fail_pulse", fail_pulse, 1);
      tick(1);
      check("wrong_lockout", locked_out, (k == 2) ? 1 : 0);
    end
    t0 = cyc;
    check("fail_pulses3", fail_seen - f0, 3);
    press(4'd1); press(4'd2);
    check("lockout_ignore", digit_count, 0);
    for (int i = 0; i < 400 && cyc < t0 + 199; i++) tick(1);
    check("lockout_last", locked_out, 1);
    tick(1);
    check("lockout_end", locked_out, 0);
    check("lockout_count0", digit_count, 0);
    enter4(16'h9876); tick(1);
    check("post_lockout_unlock", unlocked, 1);

    // Reset from OPEN and from mid-entry; default code restored.
    @(negedge hwclk) rst = 1'b1;
    tick(1);
    check("rst_open", unlocked, 0);
    @(negedge hwclk) rst = 1'b0;
    press(4'd9); press(4'd8);
    check("mid_count2", digit_count, 2);
    @(negedge hwclk) rst = 1'b1;
    tick(1);
    check("rst_mid_count", digit_count, 0);
    @(negedge hwclk) rst = 1'b0;
    enter4(16'h1234); tick(1);
    check("rst_default_code", unlocked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/keylock_ctrl.md
KEYLOCK_CTRL -- requirements
Module: keylock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning number of digits per code (1..7).
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning reset code as 4-bit digits, first-entered digit in the most significant nibble; width 4*CODE_LEN.
REQ-003 SHALL have parameter MAX_FAILS, default 3, meaning consecutive wrong codes before lockout (1..7).
REQ-004 SHALL have parameter UNLOCK_CYCLES, default 32'd60000000, meaning open time in clocks (5 s at 12 MHz).
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 32'd120000000, meaning lockout time in clocks (10 s).
REQ-006 SHALL have port hwclk, input, 1, meaning the single 12 MHz clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-008 SHALL have port button, input, 4, meaning the digit code from the keypad scanner, held stable while bstate is high and after it falls.
REQ-009 SHALL have port bstate, input, 1, meaning key-pressed indication from the keypad scanner.
REQ-010 SHALL have port unlocked, output, 1, meaning high exactly while the FSM is in OPEN.
REQ-011 SHALL have port locked_out, output, 1, meaning high exactly while the FSM is in LOCKOUT.
REQ-012 SHALL have port digit_count, output, 3, meaning digits accepted in the current sequence.
REQ-013 SHALL have port fail_pulse, output, 1, meaning a one-cycle pulse on each wrong code.
REQ-014 SHALL have port code_updated, output, 1, meaning a one-cycle pulse when a new code is stored.

Function
REQ-015 SHALL register bstate once (bstate_q) and define digit event = bstate_q & ~bstate (release); button is sampled in the event cycle.
REQ-016 SHALL ignore digit events with button > 9 (no count, no shift).
REQ-017 SHALL shift each accepted digit into a 4*CODE_LEN entry register from the LSB and increment digit_count in the same cycle.
REQ-018 SHALL implement states LOCKED, CHECK, OPEN, LOCKOUT.
REQ-019 LOCKED: accept digits; on the CODE_LEN-th digit, go to CHECK on the next cycle.
REQ-020 CHECK (1 cycle), match case: compare the entry register to the stored code; on match, clear the fail counter, load the timer with UNLOCK_CYCLES, and go to OPEN.
REQ-021 CHECK, mismatch case: pulse fail_pulse and increment the fail counter; if it reaches MAX_FAILS, clear it, load LOCKOUT_CYCLES, and go to LOCKOUT; otherwise go to LOCKED.
REQ-022 Leaving CHECK SHALL clear digit_count and the entry register.
REQ-023 OPEN: the timer decrements each cycle; accepted digits build a new sequence.
REQ-024 OPEN, sequence completes: when the CODE_LEN-th digit is accepted, the new code is written to the stored code the next cycle, code_updated pulses, and the FSM goes to LOCKED.
REQ-025 OPEN, timer reaches 0: the partial sequence is discarded, the stored code is unchanged, and the FSM goes to LOCKED.
REQ-026 Completion and timer expiry in the same cycle SHALL give completion priority.
REQ-027 LOCKOUT: all digit events are ignored and the timer decrements; at 0 go to LOCKED with digit_count = 0.
REQ-028 Latency from the final release to unlocked high SHALL be 2 cycles (CHECK, then OPEN).
REQ-029 Digit events arriving during CHECK SHALL be discarded.

Reset
REQ-030 rst SHALL force LOCKED, stored code = DEFAULT_CODE, entry = 0, digit_count = 0, fail counter = 0, timer = 0, bstate_q = 0, and all outputs 0, effective the cycle after assertion from any state (mid-entry, OPEN, LOCKOUT).

Structure
REQ-031 State encoding, digit width (4), and the max-digit constant (9) SHALL live in shared package keylock_pkg.
REQ-032 The timer SHALL be a sub-module keylock_timer (load, value, tick decrement, zero flag).

Verification
REQ-033 Reset, enter 1,2,3,4 -> unlocked = 1 exactly 2 cycles after the 4th release; fail_pulse never asserts.
REQ-034 Enter 1,2,3,5 three times (MAX_FAILS = 3) -> 3 fail_pulses; locked_out = 1 for LOCKOUT_CYCLES (sim override 200); digits entered during lockout are ignored.
REQ-035 Unlock, then enter 9,8,7,6 in OPEN -> code_updated pulse, back to LOCKED; 1,2,3,4 now fails; 9,8,7,6 unlocks.
REQ-036 Unlock with no entry, UNLOCK_CYCLES = 100 -> unlocked drops after 100 cycles; partial entry 5,5 before expiry -> code unchanged.
REQ-037 Button = 4'hB release -> digit_count unchanged; rst asserted after 2 digits -> digit_count = 0, entry 1,2,3,4 still unlocks.
